// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the core and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] input_1;
    logic [WIDTH-1:0] input_2;
    logic             flush;
    logic [WIDTH-1:0] hi_output;
    logic [WIDTH-1:0] lo_output;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, input_1, input_2, flush,
        input  hi_output, lo_output, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, input_1, input_2, flush,
        output hi_output, lo_output, busy, done, div_by_zero
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
// MULDIV_FAST_MULT_EN: when defined, MULT/MULTU finish in the accepting cycle.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             is_uns_q, is_uns_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, mb_q, mb_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dbz_q, dbz_d;
    logic             load;

    logic             in1_neg, in2_neg, a_neg, b_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
    logic             rem_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign in1_neg = ~bus.op[0] & bus.input_1[WIDTH-1];
    assign in2_neg = ~bus.op[0] & bus.input_2[WIDTH-1];
    assign mag1    = in1_neg ? -bus.input_1 : bus.input_1;
    assign mag2    = in2_neg ? -bus.input_2 : bus.input_2;
    assign a_neg   = ~is_uns_q & a_q[WIDTH-1];
    assign b_neg   = ~is_uns_q & b_q[WIDTH-1];

    // Multiply: {p_hi, p_lo} shifts right, multiplicand magnitude added into p_hi.
    assign mul_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mb_q} : '0);
    // Divide: remainder in p_hi, dividend bits shift out of p_lo, quotient bits shift in.
    assign rem_sh   = {p_hi_q, p_lo_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, mb_q};
    assign rem_ge   = ~rem_diff[WIDTH];

    assign prod_fix = (a_neg ^ b_neg) ? -{p_hi_q, p_lo_q} : {p_hi_q, p_lo_q};
    assign quo_fix  = (a_neg ^ b_neg) ? -p_lo_q : p_lo_q;
    assign rem_fix  = a_neg ? -p_hi_q : p_hi_q;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{in1_neg}}, bus.input_1} * {{WIDTH{in2_neg}}, bus.input_2};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        is_uns_d = is_uns_q;
        a_d      = a_q;
        b_d      = b_q;
        mb_d     = mb_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (bus.op == 3'b100) begin
                        hi_d = bus.input_1;
                    end else if (bus.op == 3'b101) begin
                        lo_d = bus.input_1;
                    end else if (!bus.op[2]) begin
`ifdef MULDIV_FAST_MULT_EN
                        if (!bus.op[1]) begin
                            hi_d   = fast_prod[2*WIDTH-1:WIDTH];
                            lo_d   = fast_prod[WIDTH-1:0];
                            done_d = 1'b1;
                        end else begin
                            load = 1'b1;
                        end
`else
                        load = 1'b1;
`endif
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    p_hi_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    p_lo_d = {p_lo_q[WIDTH-2:0], rem_ge};
                end else begin
                    p_hi_d = mul_sum[WIDTH:1];
                    p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (is_div_q && (b_q == '0)) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            is_div_d = bus.op[1];
            is_uns_d = bus.op[0];
            a_d      = bus.input_1;
            b_d      = bus.input_2;
            p_hi_d   = '0;
            p_lo_d   = bus.op[1] ? mag1 : mag2;
            mb_d     = bus.op[1] ? mag2 : mag1;
            cnt_d    = CW'(WIDTH - 1);
            state_d  = RUN;
        end

        // Flush abandons any in-flight work without touching HI/LO.
        if (bus.flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            is_uns_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mb_q     <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            is_uns_q <= is_uns_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mb_q     <= mb_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.hi_output   = hi_q;
    assign bus.lo_output   = lo_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus queues expected HI/LO results, a monitor checks them on done.
module tb_hilo_muldiv_unit;
    localparam int W = 32;
    localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                           OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(W)) bus ();
    hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_hi"}, bus.hi_output, mon_e.hi);
                chk({mon_e.name, "_lo"}, bus.lo_output, mon_e.lo);
                chk({mon_e.name, "_dbz"}, W'(bus.div_by_zero), W'(mon_e.dbz));
                chk({mon_e.name, "_done_cycle"}, W'(cyc), W'(mon_e.cyc));
            end
        end
    end

    function automatic int latency(logic [2:0] op);
`ifdef MULDIV_FAST_MULT_EN
        if (op[2:1] == 2'b00) return 0;
`endif
        return W + 1;
    endfunction

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic issue(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, bit push,
                         logic [W-1:0] ehi, logic [W-1:0] elo, logic edbz, string name);
        exp_t e;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.input_1 = a;
        bus.input_2 = b;
        if (push) begin
            e.hi   = ehi;
            e.lo   = elo;
            e.dbz  = edbz;
            e.cyc  = cyc + 1 + latency(op);
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; counts cycles busy was low before it.
    task automatic wait_done(string name, output int busy_lo);
        busy_lo = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done === 1'b1) begin
                chk({name, "_busy_at_done"}, W'(bus.busy), '0);
                return;
            end
            if (bus.busy !== 1'b1) busy_lo++;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout: got no done in 200 cycles expected done", name);
        sb.delete();
    endtask

    task automatic run_op(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                          logic [W-1:0] ehi, logic [W-1:0] elo, logic edbz, string name);
        int blo;
        issue(op, a, b, 1'b1, ehi, elo, edbz, name);
        wait_done(name, blo);
        if (latency(op) != 0) chk({name, "_busy_gaps"}, W'(blo), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int blo;
        reset       = 1'b1;
        bus.flush   = 1'b0;
        bus.start   = 1'b1;
        bus.op      = OP_MTHI;
        bus.input_1 = 32'hAAAA_5555;
        bus.input_2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_hi", bus.hi_output, '0);
        chk("reset_lo", bus.lo_output, '0);
        chk("reset_busy", W'(bus.busy), '0);
        chk("reset_done", W'(bus.done), '0);
        chk("reset_dbz", W'(bus.div_by_zero), '0);

        reset = 1'b0;
        @(negedge clk);
        chk("first_accept_hi", bus.hi_output, 32'hAAAA_5555);
        chk("first_accept_lo", bus.lo_output, '0);
        bus.start = 1'b0;
        @(negedge clk);

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult_neg");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, "multu_carry");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg_dividend");
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_neg_divisor");
        run_op(OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b1, "divu_by_zero");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_by_zero_neg");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_overflow");

        // Next request issued in the done cycle is accepted at the edge ending it.
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, "divu_b2b");
        wait_done("divu_b2b", blo);
        run_op(OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "mult_b2b");

        bus.start   = 1'b1;
        bus.op      = OP_MTHI;
        bus.input_1 = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_hi", bus.hi_output, 32'h1234_5678);
        chk("mthi_busy", W'(bus.busy), '0);
        bus.op      = OP_MTLO;
        bus.input_1 = 32'h9ABC_DEF0;
        @(negedge clk);
        chk("mtlo_lo", bus.lo_output, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", bus.hi_output, 32'h1234_5678);
        chk("mtlo_busy", W'(bus.busy), '0);
        bus.start = 1'b0;

        // Start while busy is ignored; operand changes after acceptance have no effect.
        issue(OP_DIVU, 32'd50, 32'd5, 1'b1, 32'd0, 32'd10, 1'b0, "divu_latched");
        repeat (3) @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = OP_MTLO;
        bus.input_1 = 32'hDEAD_BEEF;
        bus.input_2 = 32'd1;
        @(negedge clk);
        chk("busy_start_ignored_lo", bus.lo_output, 32'h9ABC_DEF0);
        bus.start = 1'b0;
        wait_done("divu_latched", blo);
        chk("divu_latched_busy_gaps", W'(blo), '0);

        // Flush at cycle 10 of a divide.
        issue(OP_DIV, 32'd100, 32'd3, 1'b0, '0, '0, 1'b0, "div_flushed");
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", W'(bus.busy), '0);
        chk("flush_hi", bus.hi_output, 32'd0);
        chk("flush_lo", bus.lo_output, 32'd10);
        repeat (W + 5) @(negedge clk);
        chk("flush_no_result_lo", bus.lo_output, 32'd10);

        bus.start   = 1'b1;
        bus.flush   = 1'b1;
        bus.op      = OP_MTHI;
        bus.input_1 = 32'h5555_AAAA;
        @(negedge clk);
        chk("flush_beats_start_hi", bus.hi_output, 32'd0);
        bus.start = 1'b0;
        bus.flush = 1'b0;

        bus.start   = 1'b1;
        bus.op      = OP_MTHI;
        bus.input_1 = 32'h1111_2222;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mthi_pre_reset", bus.hi_output, 32'h1111_2222);

        // Asynchronous reset at cycle 10 of a divide.
        issue(OP_DIV, 32'd100, 32'd3, 1'b0, '0, '0, 1'b0, "div_reset");
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_hi", bus.hi_output, '0);
        chk("async_reset_lo", bus.lo_output, '0);
        chk("async_reset_busy", W'(bus.busy), '0);
        @(negedge clk);
        reset = 1'b0;
        run_op(OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "mult_after_reset");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", W'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
